if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the CPU pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address. It takes the combinational instruction returned in the same cycle and registers it into the IF/ID pipeline register for decode.
- Handles stall, flush, branch/jump redirect, misaligned-target trap, and halt/resume. Keeps a count of fetched instructions.

---
 rtl/if_fetch_stage_pkg.sv | 21 ++
 rtl/if_fetch_stage_next_pc.sv | 65 ++++++
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// default reset/trap/bubble values and the alignment helper.
package if_fetch_stage_pkg;

   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [INST_W-1:0] DEF_TRAP_VEC = 32'h0000_0004;
   localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_BOOT = 2'd0,
      IF_RUN  = 2'd1,
      IF_HALT = 2'd2
   } if_state_e;

   function automatic logic is_word_aligned(input logic [INST_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc.sv
// Combinational next-PC / next-state decision for the fetch stage.
// Priority in RUN: redirect > flush > halt_req > stall > normal capture.
module if_next_pc
   import if_fetch_stage_pkg::*;
#(
   parameter logic [INST_W-1:0] TRAP_VEC = DEF_TRAP_VEC
) (
   input  logic [INST_W-1:0] i_pc,
   input  if_state_e         i_state,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_redirect_valid,
   input  logic [INST_W-1:0] i_redirect_pc,
   input  logic              i_halt_req,
   input  logic              i_resume,
   output logic [INST_W-1:0] o_next_pc,
   output if_state_e         o_next_state,
   output logic              o_capture,
   output logic              o_bubble,
   output logic              o_trap
);

   logic              w_misaligned;
   logic [INST_W-1:0] w_redirect_tgt;

   assign w_misaligned   = !is_word_aligned(i_redirect_pc);
   assign w_redirect_tgt = w_misaligned ? TRAP_VEC : i_redirect_pc;

   always_comb begin
      o_next_pc    = i_pc;
      o_next_state = i_state;
      o_capture    = 1'b0;
      o_bubble     = 1'b0;
      o_trap       = 1'b0;
      case (i_state)
         IF_BOOT: o_next_state = IF_RUN;
         IF_RUN: begin
            if (i_redirect_valid) begin
               o_next_pc = w_redirect_tgt;
               o_bubble  = 1'b1;
               o_trap    = w_misaligned;
            end else if (i_flush) begin
               o_bubble = 1'b1;
            end else if (i_halt_req) begin
               o_bubble     = 1'b1;
               o_next_state = IF_HALT;
            end else if (!i_stall) begin
               o_capture = 1'b1;
               o_next_pc = i_pc + 32'd4;
            end
         end
         IF_HALT: begin
            // Keeps ID empty while parked; only redirect and resume act here.
            o_bubble = 1'b1;
            if (i_redirect_valid) begin
               o_next_pc = w_redirect_tgt;
               o_trap    = w_misaligned;
            end
            if (i_resume) o_next_state = IF_RUN;
         end
         default: o_next_state = IF_BOOT;
      endcase
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// registers the returned word into the IF/ID pipeline register.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] TRAP_VEC = DEF_TRAP_VEC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
   input  logic              clk,
   input  logic              rst,
   output logic [INST_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect_valid,
   input  logic [INST_W-1:0] redirect_pc,
   input  logic              halt_req,
   input  logic              resume,
   output logic [INST_W-1:0] id_inst,
   output logic [INST_W-1:0] id_pc,
   output logic [INST_W-1:0] id_pc4,
   output logic              id_valid,
   output logic              misalign_err,
   output logic [INST_W-1:0] bad_target,
   output logic              halted,
   output logic [INST_W-1:0] fetch_count
);

   logic [INST_W-1:0] r_pc;
   if_state_e         r_state;
   logic [INST_W-1:0] r_id_inst;
   logic [INST_W-1:0] r_id_pc;
   logic [INST_W-1:0] r_id_pc4;
   logic              r_id_valid;
   logic              r_misalign;
   logic [INST_W-1:0] r_bad_target;
   logic [INST_W-1:0] r_fetch_count;

   logic [INST_W-1:0] w_next_pc;
   if_state_e         w_next_state;
   logic              w_capture;
   logic              w_bubble;
   logic              w_trap;

   if_next_pc #(
      .TRAP_VEC (TRAP_VEC)
   ) u_next_pc (
      .i_pc             (r_pc),
      .i_state          (r_state),
      .i_stall          (stall),
      .i_flush          (flush),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .i_halt_req       (halt_req),
      .i_resume         (resume),
      .o_next_pc        (w_next_pc),
      .o_next_state     (w_next_state),
      .o_capture        (w_capture),
      .o_bubble         (w_bubble),
      .o_trap           (w_trap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_state       <= IF_BOOT;
         r_id_inst     <= NOP_INST;
         r_id_pc       <= '0;
         r_id_pc4      <= '0;
         r_id_valid    <= 1'b0;
         r_misalign    <= 1'b0;
         r_bad_target  <= '0;
         r_fetch_count <= '0;
      end else begin
         r_pc       <= w_next_pc;
         r_state    <= w_next_state;
         r_misalign <= w_trap;
         if (w_trap) r_bad_target <= redirect_pc;
         // IF/ID register: capture a fetched word, or squash to a bubble.
         if (w_capture) begin
            r_id_inst     <= imem_inst;
            r_id_pc       <= r_pc;
            r_id_pc4      <= r_pc + 32'd4;
            r_id_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
         end else if (w_bubble) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
         end
      end
   end

   assign imem_addr    = r_pc;
   assign id_inst      = r_id_inst;
   assign id_pc        = r_id_pc;
   assign id_pc4       = r_id_pc4;
   assign id_valid     = r_id_valid;
   assign misalign_err = r_misalign;
   assign bad_target   = r_bad_target;
   assign halted       = (r_state == IF_HALT);
   assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: each scenario queues the expected
// stage outputs for a cycle, advances the clock and compares on pop.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall, flush, redirect_valid, halt_req, resume;
   logic [31:0] redirect_pc;
   logic [31:0] id_inst, id_pc, id_pc4, bad_target, fetch_count;
   logic        id_valid, misalign_err, halted;
   logic [31:0] mem_xor;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic        v;
      logic [31:0] inst;
      logic [31:0] cnt;
      logic        h;
      logic        m;
      logic [31:0] bad;
      logic        chk;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Memory returns a word derived from its address.
   assign imem_inst = imem_addr ^ mem_xor;

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume         (resume),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4),
      .id_valid       (id_valid),
      .misalign_err   (misalign_err),
      .bad_target     (bad_target),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   function automatic exp_t mk(input logic [31:0] addr, input logic v, input logic [31:0] inst,
                               input logic [31:0] cnt, input logic h, input logic m,
                               input logic [31:0] bad, input logic chk, input logic [31:0] pc,
                               input logic [31:0] pc4);
      return {addr, v, inst, cnt, h, m, bad, chk, chk ? pc : 32'd0, chk ? pc4 : 32'd0};
   endfunction

   function automatic exp_t observe(input logic chk);
      return {imem_addr, id_valid, id_inst, fetch_count, halted, misalign_err, bad_target,
              chk, chk ? id_pc : 32'd0, chk ? id_pc4 : 32'd0};
   endfunction

   task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                       input logic hr, input logic rs);
      stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
      halt_req = hr; resume = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst = 1'b1; mem_xor = 32'd0;
      stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0; resume = 0;
      repeat (2) @(posedge clk);
      #1;
      e = mk(32'h0, 0, 32'h0, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0);
      o = observe(1'b1);
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset got=%h exp=%h", o, e);
      end
      #3 rst = 1'b0;
   endtask

   task automatic test_normal();
      exp_t e, o;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: sb.push_back(mk(32'h0, 0, 32'h0, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0));
            1: sb.push_back(mk(32'h4, 1, 32'h0, 32'd1, 0, 0, 32'h0, 1, 32'h0, 32'h4));
            default: sb.push_back(mk(32'h8, 1, 32'h4, 32'd2, 0, 0, 32'h0, 1, 32'h4, 32'h8));
         endcase
         step(0, 0, 0, 32'h0, 0, 0);
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL normal[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_stall();
      exp_t e, o;
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            sb.push_back(mk(32'h8, 1, 32'h4, 32'd2, 0, 0, 32'h0, 1, 32'h4, 32'h8));
            step(1, 0, 0, 32'h0, 0, 0);
         end else if (k == 3) begin
            sb.push_back(mk(32'hC, 1, 32'h8, 32'd3, 0, 0, 32'h0, 1, 32'h8, 32'hC));
            step(0, 0, 0, 32'h0, 0, 0);
         end else begin
            sb.push_back(mk(32'h10, 1, 32'hC, 32'd4, 0, 0, 32'h0, 1, 32'hC, 32'h10));
            step(0, 0, 0, 32'h0, 0, 0);
         end
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_redirect();
      exp_t e, o;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin
               sb.push_back(mk(32'h100, 0, 32'h0, 32'd4, 0, 0, 32'h0, 0, 32'h0, 32'h0));
               step(1, 0, 1, 32'h100, 1, 0);
            end
            1: begin
               sb.push_back(mk(32'h104, 1, 32'h100, 32'd5, 0, 0, 32'h0, 1, 32'h100, 32'h104));
               step(0, 0, 0, 32'h0, 0, 0);
            end
            2: begin
               sb.push_back(mk(32'h4, 0, 32'h0, 32'd5, 0, 1, 32'h102, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'h102, 0, 0);
            end
            default: begin
               sb.push_back(mk(32'h8, 1, 32'h4, 32'd6, 0, 0, 32'h102, 1, 32'h4, 32'h8));
               step(0, 0, 0, 32'h0, 0, 0);
            end
         endcase
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL redirect[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_halt();
      exp_t e, o;
      for (int k = 0; k < 9; k++) begin
         if (k == 0) begin
            sb.push_back(mk(32'h20, 0, 32'h0, 32'd6, 0, 0, 32'h102, 0, 32'h0, 32'h0));
            step(0, 0, 1, 32'h20, 0, 0);
         end else if (k < 7) begin
            sb.push_back(mk(32'h20, 0, 32'h0, 32'd6, 1, 0, 32'h102, 0, 32'h0, 32'h0));
            if (k == 1) step(0, 0, 0, 32'h0, 1, 0);
            else step(1'($urandom_range(1)), 1'($urandom_range(1)), 0, 32'h0,
                      1'($urandom_range(1)), 0);
         end else if (k == 7) begin
            sb.push_back(mk(32'h20, 0, 32'h0, 32'd6, 0, 0, 32'h102, 0, 32'h0, 32'h0));
            step(0, 0, 0, 32'h0, 0, 1);
         end else begin
            sb.push_back(mk(32'h24, 1, 32'h20, 32'd7, 0, 0, 32'h102, 1, 32'h20, 32'h24));
            step(0, 0, 0, 32'h0, 0, 0);
         end
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL halt[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_halt_redirect();
      exp_t e, o;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin
               sb.push_back(mk(32'h24, 0, 32'h0, 32'd7, 1, 0, 32'h102, 0, 32'h0, 32'h0));
               step(0, 0, 0, 32'h0, 1, 0);
            end
            1: begin
               sb.push_back(mk(32'h30, 0, 32'h0, 32'd7, 1, 0, 32'h102, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'h30, 0, 0);
            end
            2: begin
               sb.push_back(mk(32'h4, 0, 32'h0, 32'd7, 1, 1, 32'h33, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'h33, 0, 0);
            end
            3: begin
               sb.push_back(mk(32'h40, 0, 32'h0, 32'd7, 0, 0, 32'h33, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'h40, 0, 1);
            end
            default: begin
               sb.push_back(mk(32'h44, 1, 32'h40, 32'd8, 0, 0, 32'h33, 1, 32'h40, 32'h44));
               step(0, 0, 0, 32'h0, 0, 0);
            end
         endcase
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL halt_redirect[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_flush_wrap();
      exp_t e, o;
      mem_xor = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin
               sb.push_back(mk(32'h44, 0, 32'h0, 32'd8, 0, 0, 32'h33, 0, 32'h0, 32'h0));
               step(1, 1, 0, 32'h0, 1, 0);
            end
            1: begin
               sb.push_back(mk(32'h48, 1, 32'hDEAD_BEAB, 32'd9, 0, 0, 32'h33, 1, 32'h44, 32'h48));
               step(0, 0, 0, 32'h0, 0, 0);
            end
            2: begin
               sb.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 32'd9, 0, 0, 32'h33, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
            end
            default: begin
               sb.push_back(mk(32'h0, 1, 32'h2152_4113, 32'd10, 0, 0, 32'h33, 1,
                               32'hFFFF_FFFC, 32'h0));
               step(0, 0, 0, 32'h0, 0, 0);
            end
         endcase
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL flush_wrap[%0d] got=%h exp=%h", k, o, e);
         end
      end
      mem_xor = 32'd0;
   endtask

   task automatic test_async_reset();
      exp_t e, o;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin
               sb.push_back(mk(32'h40, 0, 32'h0, 32'd10, 0, 0, 32'h33, 0, 32'h0, 32'h0));
               step(0, 0, 1, 32'h40, 0, 0);
            end
            1: begin
               // Assert reset mid-cycle and look before the next clock edge.
               sb.push_back(mk(32'h0, 0, 32'h0, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0));
               #3 rst = 1'b1;
               #1;
            end
            2: begin
               sb.push_back(mk(32'h0, 0, 32'h0, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0));
               step(0, 0, 0, 32'h0, 0, 0);
               #3 rst = 1'b0;
            end
            3: begin
               sb.push_back(mk(32'h0, 0, 32'h0, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0));
               step(0, 0, 1, 32'h80, 1, 0);
            end
            default: begin
               sb.push_back(mk(32'h4, 1, 32'h0, 32'd1, 0, 0, 32'h0, 1, 32'h0, 32'h4));
               step(0, 0, 0, 32'h0, 0, 0);
            end
         endcase
         e = sb.pop_front();
         o = observe(e.chk);
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset[%0d] got=%h exp=%h", k, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_stall();
      test_redirect();
      test_halt();
      test_halt_redirect();
      test_flush_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
